fpu_clk_gate_ctrl: RTL and testbench



---
 rtl/fpu_clk_gate_ctrl.sv | 101 ++++++++++
 tb/tb_fpu_clk_gate_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_clk_gate_ctrl.sv
// FPU clock-gating controller: gates the FPU clock after a run of quiet
// cycles and holds requests off with ready until the clock has restarted.
module fpu_clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             busy_i,
  input  logic             force_on_i,
  output logic             clk_en_o,
  output logic             gated_o,
  output logic [CNT_W-1:0] gate_events_o
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);

  localparam logic [1:0] ACTIVE = 2'd0;
  localparam logic [1:0] GATED  = 2'd1;
  localparam logic [1:0] WAKE   = 2'd2;

  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [WW-1:0]    wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0] gate_events_q, gate_events_d;
  logic             clk_en_q, clk_en_d;
  logic             quiet;

  assign quiet = !busy_i && !req_valid_i && !force_on_i;

  always_comb begin
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    wake_cnt_d    = wake_cnt_q;
    gate_events_d = gate_events_q;
    unique case (state_q)
      ACTIVE: begin
        if (!quiet) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = GATED;
          idle_cnt_d = '0;
          if (gate_events_q != '1)
            gate_events_d = gate_events_q + CNT_W'(1);
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      GATED: begin
        if (!quiet) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = ACTIVE;
          idle_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WW'(1);
        end
      end
      default: begin
        state_d    = ACTIVE;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
      end
    endcase
    // enable is a flop copy of the next state so it never glitches
    clk_en_d = (state_d != GATED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ACTIVE;
      idle_cnt_q    <= '0;
      wake_cnt_q    <= '0;
      gate_events_q <= '0;
      clk_en_q      <= 1'b1;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      gate_events_q <= gate_events_d;
      clk_en_q      <= clk_en_d;
    end
  end

  assign clk_en_o      = clk_en_q;
  assign req_ready_o   = (state_q == ACTIVE);
  assign gated_o       = (state_q == GATED);
  assign gate_events_o = gate_events_q;

endmodule

// File: tb/tb_fpu_clk_gate_ctrl.sv
// Bench for fpu_clk_gate_ctrl: default instance plus a tiny
// IDLE=1/WAKE=1/CNT_W=2 instance, both tracked by a reference model.
module tb_fpu_clk_gate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        busy [2];
  logic        req  [2];
  logic        frc  [2];
  logic        en   [2];
  logic        rdy  [2];
  logic        gtd  [2];
  logic [15:0] ev0;
  logic [1:0]  ev1;

  int n_cmp = 0;
  int n_bad = 0;

  int IDL  [2] = '{16, 1};
  int WK   [2] = '{2, 1};
  int MAXE [2] = '{65535, 3};

  // mode: 0 running, 1 clock stopped, 2 restarting
  int mode [2];
  int run  [2];
  int rem  [2];
  int evc  [2];

  fpu_clk_gate_ctrl dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req[0]), .req_ready_o(rdy[0]),
    .busy_i(busy[0]), .force_on_i(frc[0]),
    .clk_en_o(en[0]), .gated_o(gtd[0]),
    .gate_events_o(ev0)
  );

  fpu_clk_gate_ctrl #(
    .IDLE_CYCLES(1), .WAKE_CYCLES(1), .CNT_W(2)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req[1]), .req_ready_o(rdy[1]),
    .busy_i(busy[1]), .force_on_i(frc[1]),
    .clk_en_o(en[1]), .gated_o(gtd[1]),
    .gate_events_o(ev1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i] = 0; run[i] = 0; rem[i] = 0; evc[i] = 0;
    end
  endtask

  task automatic model_step(int i);
    bit q;
    q = !busy[i] && !req[i] && !frc[i];
    if (mode[i] == 0) begin
      run[i] = q ? run[i] + 1 : 0;
      if (run[i] >= IDL[i]) begin
        mode[i] = 1;
        run[i]  = 0;
        evc[i]  = (evc[i] < MAXE[i]) ? evc[i] + 1 : MAXE[i];
      end
    end else if (mode[i] == 1) begin
      if (!q) begin
        mode[i] = 2;
        rem[i]  = WK[i];
      end
    end else begin
      rem[i]--;
      if (rem[i] == 0) begin
        mode[i] = 0;
        run[i]  = 0;
      end
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d.clk_en", i), 32'(en[i]), 32'(mode[i] != 1));
      chk($sformatf("m%0d.ready", i), 32'(rdy[i]), 32'(mode[i] == 0));
      chk($sformatf("m%0d.gated", i), 32'(gtd[i]), 32'(mode[i] == 1));
    end
    chk("m0.events", 32'(ev0), evc[0]);
    chk("m1.events", 32'(ev1), evc[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic async_reset(string nm);
    #2 rst_n = 1'b0;
    #1;
    chk({nm, ".clk_en"}, 32'(en[0]), 1);
    chk({nm, ".ready"}, 32'(rdy[0]), 1);
    chk({nm, ".gated"}, 32'(gtd[0]), 0);
    chk({nm, ".events"}, 32'(ev0), 0);
    chk({nm, ".ev1"}, 32'(ev1), 0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; req[i] = 0; frc[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic       b, r, f;
    logic       en, rdy, g;
    logic [1:0] ev;
  } vec_t;

  vec_t tbl [18];

  initial begin
    bit acc [2];

    tbl[0]  = '{0, 0, 0, 0, 0, 1, 2'd1};
    tbl[1]  = '{0, 1, 0, 1, 0, 0, 2'd1};
    tbl[2]  = '{0, 1, 0, 1, 1, 0, 2'd1};
    tbl[3]  = '{0, 1, 0, 1, 1, 0, 2'd1};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 2'd2};
    tbl[5]  = '{1, 0, 0, 1, 0, 0, 2'd2};
    tbl[6]  = '{0, 0, 0, 1, 1, 0, 2'd2};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 2'd3};
    tbl[8]  = '{0, 0, 1, 1, 0, 0, 2'd3};
    tbl[9]  = '{0, 0, 0, 1, 1, 0, 2'd3};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 2'd3};
    tbl[11] = '{1, 0, 0, 1, 0, 0, 2'd3};
    tbl[12] = '{0, 0, 0, 1, 1, 0, 2'd3};
    tbl[13] = '{0, 0, 0, 0, 0, 1, 2'd3};
    tbl[14] = '{0, 0, 1, 1, 0, 0, 2'd3};
    tbl[15] = '{0, 0, 1, 1, 1, 0, 2'd3};
    tbl[16] = '{0, 0, 1, 1, 1, 0, 2'd3};
    tbl[17] = '{0, 0, 1, 1, 1, 0, 2'd3};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; req[i] = 0; frc[i] = 0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst.clk_en", 32'(en[0]), 1);
    chk("rst.ready", 32'(rdy[0]), 1);
    chk("rst.gated", 32'(gtd[0]), 0);
    chk("rst.events", 32'(ev0), 0);
    rst_n = 1'b1;

    // gate latency from reset
    ticks(15);
    chk("idle15.clk_en", 32'(en[0]), 1);
    tick();
    chk("idle16.clk_en", 32'(en[0]), 0);
    chk("idle16.gated", 32'(gtd[0]), 1);
    chk("idle16.events", 32'(ev0), 1);

    // wake by request, transfer at t+3
    req[0] = 1;
    tick();
    chk("wake1.clk_en", 32'(en[0]), 1);
    chk("wake1.ready", 32'(rdy[0]), 0);
    tick();
    chk("wake2.ready", 32'(rdy[0]), 0);
    tick();
    chk("wake3.ready", 32'(rdy[0]), 1);
    tick();
    req[0] = 0;
    ticks(15);
    chk("regate15.clk_en", 32'(en[0]), 1);
    tick();
    chk("regate16.gated", 32'(gtd[0]), 1);
    chk("regate16.events", 32'(ev0), 2);

    // one-cycle force pulse while gated
    frc[0] = 1;
    tick();
    frc[0] = 0;
    chk("force1.clk_en", 32'(en[0]), 1);
    chk("force1.ready", 32'(rdy[0]), 0);
    tick();
    chk("force2.ready", 32'(rdy[0]), 0);
    tick();
    chk("force3.ready", 32'(rdy[0]), 1);
    ticks(16);
    chk("force.regated", 32'(gtd[0]), 1);
    chk("force.events", 32'(ev0), 3);

    async_reset("arst_gated");

    // busy on the completing cycle restarts the idle count
    ticks(15);
    busy[0] = 1;
    tick();
    busy[0] = 0;
    ticks(15);
    chk("busy15.clk_en", 32'(en[0]), 1);
    chk("busy15.events", 32'(ev0), 0);
    tick();
    chk("busy16.gated", 32'(gtd[0]), 1);
    chk("busy16.events", 32'(ev0), 1);

    // request arriving in the very cycle GATED is entered
    req[0] = 1;
    ticks(3);
    chk("req.ready", 32'(rdy[0]), 1);
    tick();
    req[0] = 0;
    ticks(16);
    chk("edge.gated", 32'(gtd[0]), 1);
    chk("edge.events", 32'(ev0), 2);
    req[0] = 1;
    tick();
    chk("edge.next_gated", 32'(gtd[0]), 0);
    chk("edge.next_clk_en", 32'(en[0]), 1);
    chk("edge.next_events", 32'(ev0), 2);

    async_reset("arst_wake");

    // vector table on the small instance
    for (int k = 0; k < 18; k++) begin
      busy[1] = tbl[k].b;
      req[1]  = tbl[k].r;
      frc[1]  = tbl[k].f;
      tick();
      chk($sformatf("tbl%0d.clk_en", k), 32'(en[1]), 32'(tbl[k].en));
      chk($sformatf("tbl%0d.ready", k), 32'(rdy[1]), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d.gated", k), 32'(gtd[1]), 32'(tbl[k].g));
      chk($sformatf("tbl%0d.events", k), 32'(ev1), 32'(tbl[k].ev));
    end

    // random traffic, requests held until accepted
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 39) == 0);
        busy[i] = ($urandom_range(0, 29) == 0);
        frc[i]  = ($urandom_range(0, 59) == 0);
        acc[i]  = req[i] && (mode[i] == 0);
      end
      tick();
      for (int i = 0; i < 2; i++)
        if (acc[i]) req[i] = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
